// File: rtl/reset_sequencer_if.sv
// Control and status bundle of the staged reset sequencer.
// The slave modport belongs to the sequencer. The master modport belongs to the surrounding logic.
interface reset_sequencer_if #(
  parameter int STAGES = 3
);
  localparam int SW = $clog2(STAGES + 1);

  logic              i_pll_locked;
  logic              i_sw_rst;
  logic [STAGES-1:0] o_rst;
  logic [SW-1:0]     o_stage;
  logic              o_done;

  modport slave (
    input  i_pll_locked,
    input  i_sw_rst,
    output o_rst,
    output o_stage,
    output o_done
  );

  modport master (
    output i_pll_locked,
    output i_sw_rst,
    input  o_rst,
    input  o_stage,
    input  o_done
  );
endinterface

// File: rtl/reset_sequencer.sv
// Staged reset controller. Domains stay in reset until the PLL lock is qualified.
// The domains are then released one by one, in index order, with a fixed gap between releases.
module reset_sequencer #(
  parameter int STAGES       = 3,
  parameter int LOCK_CYCLES  = 16,
  parameter int STAGE_CYCLES = 8
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  reset_sequencer_if.slave    bus
);
  localparam int SW   = $clog2(STAGES + 1);
  localparam int CMAX = (LOCK_CYCLES > STAGE_CYCLES) ? LOCK_CYCLES : STAGE_CYCLES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  typedef enum logic [1:0] {WAIT_LOCK, RELEASE, RUN} state_t;

  state_t            state_reg;
  logic [CW-1:0]     count_reg;
  logic [SW-1:0]     index_reg;
  logic              sync1_reg;
  logic              locked_s_reg;
  logic [STAGES-1:0] clear_mask;
  logic              abort;
  logic              lock_hit;
  logic              stage_hit;
  logic              last_stage;

  // Two-flop synchroniser for the asynchronous lock input
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_reg    <= 1'b0;
      locked_s_reg <= 1'b0;
    end else begin
      sync1_reg    <= bus.i_pll_locked;
      locked_s_reg <= sync1_reg;
    end
  end

  // One-hot mask selecting the domain released on the next stage timeout
  for (genvar gi = 0; gi < STAGES; gi++) begin : g_mask
    assign clear_mask[gi] = (index_reg == SW'(gi));
  end

  assign abort      = bus.i_sw_rst || (!locked_s_reg && (state_reg != WAIT_LOCK));
  assign lock_hit   = (count_reg == CW'(LOCK_CYCLES - 1));
  assign stage_hit  = (count_reg == CW'(STAGE_CYCLES - 1));
  assign last_stage = (index_reg == SW'(STAGES - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg   <= WAIT_LOCK;
      count_reg   <= '0;
      index_reg   <= '0;
      bus.o_rst   <= '1;
      bus.o_stage <= '0;
      bus.o_done  <= 1'b0;
    end else if (abort) begin
      // Reassertion is always all-at-once and takes precedence over a pending release
      state_reg   <= WAIT_LOCK;
      count_reg   <= '0;
      index_reg   <= '0;
      bus.o_rst   <= '1;
      bus.o_stage <= '0;
      bus.o_done  <= 1'b0;
    end else begin
      case (state_reg)
        WAIT_LOCK: begin
          if (!locked_s_reg) begin
            count_reg <= '0;
          end else if (lock_hit) begin
            state_reg <= RELEASE;
            count_reg <= '0;
            index_reg <= '0;
          end else begin
            count_reg <= count_reg + CW'(1);
          end
        end
        RELEASE: begin
          if (stage_hit) begin
            bus.o_rst   <= bus.o_rst & ~clear_mask;
            bus.o_stage <= index_reg + SW'(1);
            count_reg   <= '0;
            index_reg   <= index_reg + SW'(1);
            if (last_stage) begin
              state_reg  <= RUN;
              bus.o_done <= 1'b1;
            end
          end else begin
            count_reg <= count_reg + CW'(1);
          end
        end
        RUN: begin
          bus.o_rst   <= '0;
          bus.o_stage <= SW'(STAGES);
          bus.o_done  <= 1'b1;
        end
        default: begin
          state_reg <= WAIT_LOCK;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer. It uses a table of edge checkpoints and a few hand-written sequences.
// Edge numbers count rising edges after the reset is released.
module tb_reset_sequencer;
  logic clk = 1'b0;
  logic rst_n;
  int   edge_n = 0;
  int   total  = 0;
  int   bad    = 0;

  reset_sequencer_if #(.STAGES(3)) bus ();

  reset_sequencer #(
    .STAGES(3),
    .LOCK_CYCLES(16),
    .STAGE_CYCLES(8)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog edge=%0d got timeout want completion", edge_n);
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    int         at_edge;
    logic       lock;
    logic       sw;
    logic [2:0] rst;
    logic [1:0] stage;
    logic       done;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge clk);
    edge_n++;
    #1;
  endtask

  task automatic check(input string name, input logic [2:0] er, input logic [1:0] es, input logic ed);
    total++;
    if ({bus.o_rst, bus.o_stage, bus.o_done} !== {er, es, ed}) begin
      bad++;
      $display("FAIL %s edge=%0d got rst=%b stage=%0d done=%b want rst=%b stage=%0d done=%b",
               name, edge_n, bus.o_rst, bus.o_stage, bus.o_done, er, es, ed);
    end else begin
      $display("ok   %s edge=%0d rst=%b stage=%0d done=%b", name, edge_n, bus.o_rst, bus.o_stage, bus.o_done);
    end
  endtask

  task automatic do_reset(input logic lock);
    rst_n            = 1'b0;
    bus.i_pll_locked = lock;
    bus.i_sw_rst     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    edge_n = 0;
  endtask

  initial begin
    // Inputs in a record are applied after that record's check, so they are first sampled at at_edge+1.
    vecs.push_back('{0,   1'b1, 1'b0, 3'b111, 2'd0, 1'b0});
    vecs.push_back('{25,  1'b1, 1'b0, 3'b111, 2'd0, 1'b0});
    vecs.push_back('{26,  1'b1, 1'b0, 3'b110, 2'd1, 1'b0});
    vecs.push_back('{29,  1'b1, 1'b1, 3'b110, 2'd1, 1'b0});
    vecs.push_back('{30,  1'b1, 1'b0, 3'b111, 2'd0, 1'b0});
    vecs.push_back('{53,  1'b1, 1'b0, 3'b111, 2'd0, 1'b0});
    vecs.push_back('{54,  1'b1, 1'b0, 3'b110, 2'd1, 1'b0});
    vecs.push_back('{62,  1'b1, 1'b0, 3'b100, 2'd2, 1'b0});
    vecs.push_back('{69,  1'b1, 1'b0, 3'b100, 2'd2, 1'b0});
    vecs.push_back('{70,  1'b1, 1'b0, 3'b000, 2'd3, 1'b1});
    vecs.push_back('{80,  1'b0, 1'b0, 3'b000, 2'd3, 1'b1});
    vecs.push_back('{82,  1'b0, 1'b0, 3'b000, 2'd3, 1'b1});
    vecs.push_back('{83,  1'b0, 1'b0, 3'b111, 2'd0, 1'b0});
    vecs.push_back('{90,  1'b1, 1'b0, 3'b111, 2'd0, 1'b0});
    vecs.push_back('{115, 1'b1, 1'b0, 3'b111, 2'd0, 1'b0});
    vecs.push_back('{116, 1'b1, 1'b0, 3'b110, 2'd1, 1'b0});
    vecs.push_back('{123, 1'b1, 1'b1, 3'b110, 2'd1, 1'b0});
    vecs.push_back('{124, 1'b1, 1'b0, 3'b111, 2'd0, 1'b0});
    vecs.push_back('{147, 1'b1, 1'b0, 3'b111, 2'd0, 1'b0});
    vecs.push_back('{148, 1'b1, 1'b1, 3'b110, 2'd1, 1'b0});
    vecs.push_back('{155, 1'b1, 1'b1, 3'b111, 2'd0, 1'b0});
    vecs.push_back('{160, 1'b1, 1'b0, 3'b111, 2'd0, 1'b0});
    vecs.push_back('{183, 1'b1, 1'b0, 3'b111, 2'd0, 1'b0});
    vecs.push_back('{184, 1'b1, 1'b0, 3'b110, 2'd1, 1'b0});

    // The table covers the nominal release, a software reset after stage 0, RUN, and a lock loss in RUN.
    // It also covers an abort that lands on a stage timeout and a held software reset.
    do_reset(1'b1);
    foreach (vecs[i]) begin
      while (edge_n < vecs[i].at_edge) tick();
      check($sformatf("vec%0d", i), vecs[i].rst, vecs[i].stage, vecs[i].done);
      bus.i_pll_locked = vecs[i].lock;
      bus.i_sw_rst     = vecs[i].sw;
    end

    // Lock is first sampled high at edge 9, so stage 0 is released at edge 34.
    do_reset(1'b0);
    check("late_lock_reset", 3'b111, 2'd0, 1'b0);
    while (edge_n < 8) tick();
    bus.i_pll_locked = 1'b1;
    while (edge_n < 33) begin
      tick();
      check("late_lock_hold", 3'b111, 2'd0, 1'b0);
    end
    tick();
    check("late_lock_rel0", 3'b110, 2'd1, 1'b0);

    // A one-sample lock glitch at edge 13 restarts qualification, so stage 0 is released at edge 39.
    do_reset(1'b1);
    while (edge_n < 12) tick();
    bus.i_pll_locked = 1'b0;
    tick();
    bus.i_pll_locked = 1'b1;
    while (edge_n < 38) begin
      tick();
      check("glitch_hold", 3'b111, 2'd0, 1'b0);
    end
    tick();
    check("glitch_rel0", 3'b110, 2'd1, 1'b0);

    // Asynchronous reset between edges in RELEASE clears the outputs before the next edge.
    do_reset(1'b1);
    while (edge_n < 30) tick();
    check("async_pre", 3'b110, 2'd1, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_now", 3'b111, 2'd0, 1'b0);
    @(posedge clk);
    #1;
    check("async_held", 3'b111, 2'd0, 1'b0);
    @(negedge clk);
    rst_n  = 1'b1;
    edge_n = 0;
    while (edge_n < 25) tick();
    check("async_redo25", 3'b111, 2'd0, 1'b0);
    tick();
    check("async_redo26", 3'b110, 2'd1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
